ads1115_scan_ctrl: RTL

Sequencer that drives the ADS1115 ADC through a byte-level I2C master engine: for each enabled channel it writes the config register (single-shot, single-ended MUX), waits for conversion, selects the conversion register, reads the 16-bit result and publishes it. It sits between the shared I2C byte engine and the 3LFCC control logic, scanning AIN0..AIN3 round-robin and reporting NACK failures.

---
 rtl/ads1115_scan_ctrl.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/ads1115_scan_ctrl.sv
// ADS1115 round-robin scan sequencer on top of a byte-level I2C command/response engine.
// Define ADS_OS_POLL_EN to poll the OS bit instead of waiting a fixed CONV_CYCLES.
module ads1115_scan_ctrl #(
    parameter logic [6:0] I2C_ADDR    = 7'h49,
    parameter logic [2:0] PGA         = 3'b010,
    parameter logic [2:0] DR          = 3'b100,
    parameter int         CONV_CYCLES = 216000,
    parameter int         POLL_MAX    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [3:0]  chan_mask,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [2:0]  cmd_op,
    output logic [7:0]  cmd_data,
    input  logic        rsp_valid,
    input  logic [7:0]  rsp_data,
    input  logic        rsp_nack,
    output logic        result_valid,
    output logic [1:0]  result_chan,
    output logic [15:0] result_data,
    output logic        busy,
    output logic        err_pulse
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_RSP  = 3'd2;
    localparam logic [2:0] S_CONV_WAIT = 3'd3;
    localparam logic [2:0] S_PUBLISH   = 3'd4;
    localparam logic [2:0] S_ABORT     = 3'd5;

    localparam logic [2:0] OP_START     = 3'd0;
    localparam logic [2:0] OP_STOP      = 3'd1;
    localparam logic [2:0] OP_WRITE     = 3'd2;
    localparam logic [2:0] OP_READ_ACK  = 3'd3;
    localparam logic [2:0] OP_READ_NACK = 3'd4;

    localparam logic [7:0] ADDR_W  = {I2C_ADDR, 1'b0};
    localparam logic [7:0] ADDR_R  = {I2C_ADDR, 1'b1};
    localparam logic [7:0] CFG_LSB = {DR, 5'b00011};

    // Step numbering: config 0..5, optional poll block, pointer block, read block.
    localparam logic [4:0] A_STOP    = 5'd5;
`ifdef ADS_OS_POLL_EN
    localparam logic [4:0] POLL_BASE = 5'd6;
    localparam logic [4:0] C_BASE    = 5'd15;
    localparam int         PCW       = $clog2(POLL_MAX + 1);
`else
    localparam logic [4:0] C_BASE    = 5'd6;
    localparam int         TW        = $clog2(CONV_CYCLES + 1);
`endif
    localparam logic [4:0] D_BASE    = C_BASE + 5'd4;
    localparam logic [4:0] LAST_STEP = D_BASE + 5'd4;

    logic [2:0]  state_reg;
    logic [4:0]  step_reg;
    logic [1:0]  chan_reg;
    logic [15:0] data_reg;
    logic        cmd_valid_reg;
    logic [2:0]  cmd_op_reg;
    logic [7:0]  cmd_data_reg;
    logic        result_valid_reg;
    logic [1:0]  result_chan_reg;
    logic [15:0] result_data_reg;
    logic        err_pulse_reg;
    logic        abort_sent_reg;
`ifdef ADS_OS_POLL_EN
    logic [PCW-1:0] poll_cnt_reg;
`else
    logic [TW-1:0]  timer_reg;
`endif

    logic [1:0]  next_chan;
    logic [1:0]  cand;
    logic        found;
    logic [10:0] cur_cmd;

    function automatic logic [10:0] step_cmd(input logic [4:0] step, input logic [1:0] ch);
        logic [10:0] r;
        logic [4:0]  idx;
        r   = {OP_STOP, 8'h00};
        idx = 5'd0;
        if (step <= A_STOP) begin
            case (step)
                5'd0:    r = {OP_START, 8'h00};
                5'd1:    r = {OP_WRITE, ADDR_W};
                5'd2:    r = {OP_WRITE, 8'h01};
                5'd3:    r = {OP_WRITE, 1'b1, 1'b1, ch, PGA, 1'b1};
                5'd4:    r = {OP_WRITE, CFG_LSB};
                default: r = {OP_STOP, 8'h00};
            endcase
        end
`ifdef ADS_OS_POLL_EN
        else if (step < C_BASE) begin
            idx = step - POLL_BASE;
            case (idx)
                5'd0:    r = {OP_START, 8'h00};
                5'd1:    r = {OP_WRITE, ADDR_W};
                5'd2:    r = {OP_WRITE, 8'h01};
                5'd4:    r = {OP_START, 8'h00};
                5'd5:    r = {OP_WRITE, ADDR_R};
                5'd6:    r = {OP_READ_ACK, 8'h00};
                5'd7:    r = {OP_READ_NACK, 8'h00};
                default: r = {OP_STOP, 8'h00};
            endcase
        end
`endif
        else if (step < D_BASE) begin
            idx = step - C_BASE;
            case (idx)
                5'd0:    r = {OP_START, 8'h00};
                5'd1:    r = {OP_WRITE, ADDR_W};
                5'd2:    r = {OP_WRITE, 8'h00};
                default: r = {OP_STOP, 8'h00};
            endcase
        end else begin
            idx = step - D_BASE;
            case (idx)
                5'd0:    r = {OP_START, 8'h00};
                5'd1:    r = {OP_WRITE, ADDR_R};
                5'd2:    r = {OP_READ_ACK, 8'h00};
                5'd3:    r = {OP_READ_NACK, 8'h00};
                default: r = {OP_STOP, 8'h00};
            endcase
        end
        return r;
    endfunction

    assign cur_cmd = step_cmd(step_reg, chan_reg);

    // Round-robin: first enabled channel strictly after the last one, wrapping 3 -> 0.
    always_comb begin
        next_chan = chan_reg;
        cand      = 2'd0;
        found     = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cand = chan_reg + 2'(i);
            if (!found && chan_mask[cand]) begin
                next_chan = cand;
                found     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= S_IDLE;
            step_reg         <= 5'd0;
            chan_reg         <= 2'd3;
            data_reg         <= 16'h0000;
            cmd_valid_reg    <= 1'b0;
            cmd_op_reg       <= 3'd0;
            cmd_data_reg     <= 8'h00;
            result_valid_reg <= 1'b0;
            result_chan_reg  <= 2'd0;
            result_data_reg  <= 16'h0000;
            err_pulse_reg    <= 1'b0;
            abort_sent_reg   <= 1'b0;
`ifdef ADS_OS_POLL_EN
            poll_cnt_reg     <= '0;
`else
            timer_reg        <= '0;
`endif
        end else begin
            result_valid_reg <= 1'b0;
            err_pulse_reg    <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (enable && (chan_mask != 4'd0)) begin
                        chan_reg  <= next_chan;
                        step_reg  <= 5'd0;
                        state_reg <= S_ISSUE;
`ifdef ADS_OS_POLL_EN
                        poll_cnt_reg <= '0;
`endif
                    end
                end
                S_ISSUE: begin
                    if (!cmd_valid_reg) begin
                        cmd_valid_reg <= 1'b1;
                        cmd_op_reg    <= cur_cmd[10:8];
                        cmd_data_reg  <= cur_cmd[7:0];
                    end else if (cmd_ready) begin
                        cmd_valid_reg <= 1'b0;
                        state_reg     <= S_WAIT_RSP;
                    end
                end
                S_WAIT_RSP: begin
                    if (rsp_valid) begin
                        if (cur_cmd[10:8] == OP_WRITE && rsp_nack) begin
                            abort_sent_reg <= 1'b0;
                            state_reg      <= S_ABORT;
                        end else begin
                            if (cur_cmd[10:8] == OP_READ_ACK)  data_reg[15:8] <= rsp_data;
                            if (cur_cmd[10:8] == OP_READ_NACK) data_reg[7:0]  <= rsp_data;
                            if (step_reg == LAST_STEP) begin
                                result_valid_reg <= 1'b1;
                                result_chan_reg  <= chan_reg;
                                result_data_reg  <= data_reg;
                                state_reg        <= S_PUBLISH;
                            end
`ifdef ADS_OS_POLL_EN
                            // data_reg[15] holds OS from this poll's READ_ACK.
                            else if (step_reg == C_BASE - 5'd1) begin
                                if (data_reg[15]) begin
                                    step_reg  <= C_BASE;
                                    state_reg <= S_ISSUE;
                                end else if (poll_cnt_reg == PCW'(POLL_MAX - 1)) begin
                                    err_pulse_reg <= 1'b1;
                                    state_reg     <= S_IDLE;
                                end else begin
                                    poll_cnt_reg <= poll_cnt_reg + PCW'(1);
                                    step_reg     <= POLL_BASE;
                                    state_reg    <= S_ISSUE;
                                end
                            end
`else
                            // Load leaves room for the two cycles of ISSUE entry latency.
                            else if (step_reg == A_STOP) begin
                                timer_reg <= TW'(CONV_CYCLES - 3);
                                step_reg  <= C_BASE;
                                state_reg <= S_CONV_WAIT;
                            end
`endif
                            else begin
                                step_reg  <= step_reg + 5'd1;
                                state_reg <= S_ISSUE;
                            end
                        end
                    end
                end
`ifndef ADS_OS_POLL_EN
                S_CONV_WAIT: begin
                    if (timer_reg == '0) state_reg <= S_ISSUE;
                    else                 timer_reg <= timer_reg - TW'(1);
                end
`endif
                S_PUBLISH: state_reg <= S_IDLE;
                S_ABORT: begin
                    if (!abort_sent_reg) begin
                        if (!cmd_valid_reg) begin
                            cmd_valid_reg <= 1'b1;
                            cmd_op_reg    <= OP_STOP;
                            cmd_data_reg  <= 8'h00;
                        end else if (cmd_ready) begin
                            cmd_valid_reg  <= 1'b0;
                            abort_sent_reg <= 1'b1;
                        end
                    end else if (rsp_valid) begin
                        err_pulse_reg <= 1'b1;
                        state_reg     <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign cmd_valid    = cmd_valid_reg;
    assign cmd_op       = cmd_op_reg;
    assign cmd_data     = cmd_data_reg;
    assign result_valid = result_valid_reg;
    assign result_chan  = result_chan_reg;
    assign result_data  = result_data_reg;
    assign err_pulse    = err_pulse_reg;
    assign busy         = (state_reg != S_IDLE);

endmodule
